flag_register: RTL and testbench
================================

Name: flag_register

Overview:
- Architectural NZCV status register sitting directly upstream of the condition evaluator.
- Latches flags from the execute-stage ALU result.
- Drives the registered flag vector the condition evaluator consumes, plus a same-cycle bypass copy for back-to-back dependent conditional instructions.
- Includes a small save/restore stack for interrupt entry/exit.

Parameters:
- WIDTH, 16, ALU result width used to derive N and Z.
- SHADOW_DEPTH, 2, number of flag entries the save/restore stack holds (1..8).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  execute stage presents a valid instruction this cycle.
- set_flags  in  1  instruction requests a flag update (S bit).
- cond_pass  in  1  condition-evaluator verdict for this instruction.
- flush  in  1  squash the current execute-stage instruction.
- alu_result  in  WIDTH  ALU result.
- alu_carry  in  1  ALU carry-out.
- alu_overflow  in  1  ALU signed overflow.
- update_cv  in  1  1 = arithmetic op, C and V are written; 0 = logical op, C and V are preserved.
- save  in  1  push current flags onto the stack.
- restore  in  1  pop the top of the stack into flags.
- err_clr  in  1  clear err.
- flags  out  4  registered flags: [3]=N, [2]=Z, [1]=C, [0]=V.
- flags_bypass  out  4  combinational next-state flags.
- stack_empty  out  1  stack holds 0 entries.
- stack_full  out  1  stack holds SHADOW_DEPTH entries.
- err  out  1  sticky stack-misuse error.

Behaviour:
- Reset (async, active-high): flags=4'b0000, stack count=0, stack_empty=1, stack_full=0, err=0. All state clears immediately, independent of clk.
- Update enable: upd = in_valid & set_flags & cond_pass & ~flush.
- On upd at rising edge:
  - N <= alu_result[WIDTH-1]
  - Z <= (alu_result == 0)
  - C <= update_cv ? alu_carry : C
  - V <= update_cv ? alu_overflow : V
- No upd: flags hold.
- flags_bypass equals the value flags will take at the next edge, including restore and upd effects. It is purely combinational, with zero latency.
- Latency: flag update visible on flags one cycle after the qualifying edge; on flags_bypass the same cycle.
- Save (push), restore=0:
  - if not full, stack[count] <= flags (pre-update value) and count++.
  - A simultaneous upd still updates flags.
- Restore (pop), save=0:
  - if not empty, flags <= stack[count-1] and count--.
  - Restore has priority over upd; the upd is dropped.
- Save while full: no stack change, err <= 1, flags behave as if save were 0.
- Restore while empty: no stack change, flags follow upd normally, err <= 1.
- save & restore in the same cycle: no stack change, no restore, err <= 1; upd still applies.
- flush suppresses only upd; save/restore are unaffected by flush.
- err: sticky. Cleared by err_clr. A set condition in the same cycle as err_clr wins (err stays 1).
- Stack occupancy:
  - stack_empty = (count==0)
  - stack_full = (count==SHADOW_DEPTH)
  - both registered-derived, no glitch paths from inputs.
- Stack contents need not reset; only count resets.
- All inputs are sampled only at the rising clk edge. X on alu_* is tolerated when upd=0.

Decomposition:
- Shared package holds:
  - flag bit index constants: FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - the 4-bit flags type.
  - condition-code encodings, also used by the condition evaluator.
- One natural sub-module: flag_stack. It is a parameterised LIFO with push/pop/full/empty/err handling.
- flag_register instantiates flag_stack and holds the NZCV register and next-state logic.

Test Plan:
1. Reset mid-update: assert rst while upd with alu_result=0 -> flags=0000 immediately, err=0, stack_empty=1.
2. WIDTH=16, upd with alu_result=16'h8000, alu_carry=1, alu_overflow=1, update_cv=1 -> flags_bypass=1011 same cycle, flags=1011 next cycle. Then a logical op with alu_result=0, update_cv=0 -> flags=0111 (C, V preserved).
3. Suppression: cond_pass=0 or flush=1 with set_flags=1, alu_result=0 -> flags unchanged. set_flags=0 -> unchanged.
4. Save/restore round trip: flags=1000, save; then upd to 0100; then restore -> flags=1000, stack_empty=1. Restore with simultaneous upd (alu_result=0) -> restored value wins.
5. Stack misuse with SHADOW_DEPTH=2:
   - three saves -> stack_full=1 after the second, err=1 after the third.
   - err_clr -> err=0.
   - three restores -> err=1 on the third, flags equal the first saved value.
6. save & restore in the same cycle with count=1 -> count stays 1, err=1, a concurrent upd applies.

Source files
------------

// File: rtl/flag_register_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : flag_register_pkg                                          |
// | Description : Shared NZCV flag definitions: bit indices, the 4-bit flag  |
// |               vector type, condition-code encodings and a condition      |
// |               evaluation helper used by the condition evaluator.         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package flag_register_pkg;

    // Bit positions inside the flag vector
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef logic [3:0] flags_t;

    // Condition codes consumed by the downstream condition evaluator
    typedef enum logic [3:0] {
        COND_EQ = 4'h0,
        COND_NE = 4'h1,
        COND_CS = 4'h2,
        COND_CC = 4'h3,
        COND_MI = 4'h4,
        COND_PL = 4'h5,
        COND_VS = 4'h6,
        COND_VC = 4'h7,
        COND_HI = 4'h8,
        COND_LS = 4'h9,
        COND_GE = 4'hA,
        COND_LT = 4'hB,
        COND_GT = 4'hC,
        COND_LE = 4'hD,
        COND_AL = 4'hE,
        COND_NV = 4'hF
    } cond_t;

    function automatic logic cond_holds(input cond_t cond, input flags_t f);
        logic n;
        logic z;
        logic c;
        logic v;
        logic r;
        n = f[FLAG_N];
        z = f[FLAG_Z];
        c = f[FLAG_C];
        v = f[FLAG_V];
        case (cond)
            COND_EQ: r = z;
            COND_NE: r = ~z;
            COND_CS: r = c;
            COND_CC: r = ~c;
            COND_MI: r = n;
            COND_PL: r = ~n;
            COND_VS: r = v;
            COND_VC: r = ~v;
            COND_HI: r = c & ~z;
            COND_LS: r = ~c | z;
            COND_GE: r = (n == v);
            COND_LT: r = (n != v);
            COND_GT: r = ~z & (n == v);
            COND_LE: r = z | (n != v);
            COND_AL: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage : flag_register_pkg
`default_nettype wire

// File: rtl/flag_register_stack.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : flag_stack                                                 |
// | Description : Parameterised LIFO of flag vectors for interrupt           |
// |               save/restore, with sticky misuse error.                    |
// | Ports       : clk, rst (async, active-high)                              |
// |               push_i / pop_i      - save / restore requests              |
// |               err_clr_i           - clear the sticky error               |
// |               push_data_i         - flags to save                        |
// |               pop_data_o          - entry at the top of the stack        |
// |               pop_ok_o            - a legal pop happens this cycle       |
// |               empty_o / full_o    - occupancy, derived from registers    |
// |               err_o               - sticky misuse error                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module flag_stack
    import flag_register_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push_i,
    input  logic   pop_i,
    input  logic   err_clr_i,
    input  flags_t push_data_i,
    output flags_t pop_data_o,
    output logic   pop_ok_o,
    output logic   empty_o,
    output logic   full_o,
    output logic   err_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             err_q;
    logic             err_d;
    logic             push_ok;
    logic             pop_ok;
    logic             misuse;
    flags_t           mem_q [DEPTH];

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));

    // A simultaneous push and pop is treated as misuse and does nothing
    assign push_ok = push_i & ~pop_i & ~full_o;
    assign pop_ok  = pop_i & ~push_i & ~empty_o;
    assign misuse  = (push_i & pop_i)
                   | (push_i & ~pop_i & full_o)
                   | (pop_i & ~push_i & empty_o);

    always_comb begin
        count_d = count_q;
        if (push_ok) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_ok) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // A new error in the same cycle as a clear keeps the error set
    always_comb begin
        err_d = err_q;
        if (misuse) begin
            err_d = 1'b1;
        end else if (err_clr_i) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // Storage is not reset; only the occupancy count is
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        always_ff @(posedge clk) begin
            if (push_ok && (count_q == CNT_W'(i))) begin
                mem_q[i] <= push_data_i;
            end
        end
    end

    // Top-of-stack read: entry count-1
    always_comb begin
        pop_data_o = mem_q[0];
        for (int i = 0; i < DEPTH; i++) begin
            if (count_q == CNT_W'(i + 1)) begin
                pop_data_o = mem_q[i];
            end
        end
    end

    assign pop_ok_o = pop_ok;
    assign err_o    = err_q;

endmodule : flag_stack
`default_nettype wire

// File: rtl/flag_register.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : flag_register                                              |
// | Description : Architectural NZCV status register with same-cycle bypass  |
// |               and an interrupt save/restore stack.                       |
// | Ports       : clk, rst (async, active-high)                              |
// |               in_valid, set_flags, cond_pass, flush - update qualifiers  |
// |               alu_result/alu_carry/alu_overflow     - ALU outcome        |
// |               update_cv   - write C/V (arithmetic) or keep them          |
// |               save/restore/err_clr - stack control                       |
// |               flags        - registered NZCV                             |
// |               flags_bypass - next-state NZCV (combinational)             |
// |               stack_empty/stack_full/err - stack status                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module flag_register
    import flag_register_pkg::*;
#(
    parameter int WIDTH        = 16,
    parameter int SHADOW_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             set_flags,
    input  logic             cond_pass,
    input  logic             flush,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carry,
    input  logic             alu_overflow,
    input  logic             update_cv,
    input  logic             save,
    input  logic             restore,
    input  logic             err_clr,
    output logic [3:0]       flags,
    output logic [3:0]       flags_bypass,
    output logic             stack_empty,
    output logic             stack_full,
    output logic             err
);

    flags_t flags_q;
    flags_t flags_d;
    flags_t pop_data;
    logic   pop_ok;
    logic   upd;

    assign upd = in_valid & set_flags & cond_pass & ~flush;

    flag_stack #(
        .DEPTH (SHADOW_DEPTH)
    ) u_stack (
        .clk         (clk),
        .rst         (rst),
        .push_i      (save),
        .pop_i       (restore),
        .err_clr_i   (err_clr),
        .push_data_i (flags_q),
        .pop_data_o  (pop_data),
        .pop_ok_o    (pop_ok),
        .empty_o     (stack_empty),
        .full_o      (stack_full),
        .err_o       (err)
    );

    // A successful restore overrides any concurrent flag update
    always_comb begin
        flags_d = flags_q;
        if (pop_ok) begin
            flags_d = pop_data;
        end else if (upd) begin
            flags_d[FLAG_N] = alu_result[WIDTH-1];
            flags_d[FLAG_Z] = (alu_result == '0);
            if (update_cv) begin
                flags_d[FLAG_C] = alu_carry;
                flags_d[FLAG_V] = alu_overflow;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q <= 4'b0000;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign flags        = flags_q;
    assign flags_bypass = flags_d;

endmodule : flag_register
`default_nettype wire

// File: tb/tb_flag_register.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_flag_register                                           |
// | Description : Self-checking bench for flag_register (WIDTH=16, depth 2). |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_flag_register;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        set_flags;
    logic        cond_pass;
    logic        flush;
    logic [15:0] alu_result;
    logic        alu_carry;
    logic        alu_overflow;
    logic        update_cv;
    logic        save;
    logic        restore;
    logic        err_clr;
    logic [3:0]  flags;
    logic [3:0]  flags_bypass;
    logic        stack_empty;
    logic        stack_full;
    logic        err;

    int errors;
    int checks;

    flag_register #(
        .WIDTH        (16),
        .SHADOW_DEPTH (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .set_flags    (set_flags),
        .cond_pass    (cond_pass),
        .flush        (flush),
        .alu_result   (alu_result),
        .alu_carry    (alu_carry),
        .alu_overflow (alu_overflow),
        .update_cv    (update_cv),
        .save         (save),
        .restore      (restore),
        .err_clr      (err_clr),
        .flags        (flags),
        .flags_bypass (flags_bypass),
        .stack_empty  (stack_empty),
        .stack_full   (stack_full),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  qual;   // {in_valid, set_flags, cond_pass, flush}
        logic [15:0] res;
        logic        ca;
        logic        ov;
        logic        cv;
        logic        sv;
        logic        rs;
        logic        ec;
        logic [3:0]  byp;
        logic [3:0]  fl;
        logic        em;
        logic        fu;
        logic        er;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [3:0] qual, input logic [15:0] res,
                                input logic ca, input logic ov, input logic cv,
                                input logic sv, input logic rs, input logic ec,
                                input logic [3:0] byp, input logic [3:0] fl,
                                input logic em, input logic fu, input logic er);
        vec_t v;
        v.qual = qual; v.res = res; v.ca = ca; v.ov = ov; v.cv = cv;
        v.sv = sv; v.rs = rs; v.ec = ec;
        v.byp = byp; v.fl = fl; v.em = em; v.fu = fu; v.er = er;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [3:0] act,
                       input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec=%0d actual=%b expected=%b", name, idx, act, exp);
        end
    endtask

    task automatic drive_idle();
        in_valid = 1'b0; set_flags = 1'b0; cond_pass = 1'b0; flush = 1'b0;
        alu_result = 16'h0; alu_carry = 1'b0; alu_overflow = 1'b0;
        update_cv = 1'b0; save = 1'b0; restore = 1'b0; err_clr = 1'b0;
    endtask

    localparam logic [3:0] U  = 4'b1110; // qualifying update
    localparam logic [3:0] NO = 4'b0000;

    initial begin
        errors = 0;
        checks = 0;
        drive_idle();
        rst = 1'b1;

        //         qual     res      ca ov cv sv rs ec  byp      fl      em fu er
        vecs.push_back(mk(U,       16'h8000, 1, 1, 1, 0, 0, 0, 4'b1011, 4'b1011, 1, 0, 0));
        vecs.push_back(mk(U,       16'h0000, 0, 0, 0, 0, 0, 0, 4'b0111, 4'b0111, 1, 0, 0));
        vecs.push_back(mk(4'b1100, 16'h0000, 0, 0, 1, 0, 0, 0, 4'b0111, 4'b0111, 1, 0, 0));
        vecs.push_back(mk(4'b1111, 16'h0000, 0, 0, 1, 0, 0, 0, 4'b0111, 4'b0111, 1, 0, 0));
        vecs.push_back(mk(4'b1010, 16'h0000, 0, 0, 1, 0, 0, 0, 4'b0111, 4'b0111, 1, 0, 0));
        vecs.push_back(mk(4'b0110, 16'h0000, 0, 0, 1, 0, 0, 0, 4'b0111, 4'b0111, 1, 0, 0));
        vecs.push_back(mk(U,       16'h8000, 0, 0, 1, 0, 0, 0, 4'b1000, 4'b1000, 1, 0, 0));
        vecs.push_back(mk(NO,      16'h0000, 0, 0, 0, 1, 0, 0, 4'b1000, 4'b1000, 0, 0, 0));
        vecs.push_back(mk(U,       16'h0000, 0, 0, 1, 0, 0, 0, 4'b0100, 4'b0100, 0, 0, 0));
        vecs.push_back(mk(NO,      16'h0000, 0, 0, 0, 0, 1, 0, 4'b1000, 4'b1000, 1, 0, 0));
        vecs.push_back(mk(U,       16'h0001, 1, 0, 1, 1, 0, 0, 4'b0010, 4'b0010, 0, 0, 0));
        vecs.push_back(mk(U,       16'h0000, 1, 1, 1, 0, 1, 0, 4'b1000, 4'b1000, 1, 0, 0));
        vecs.push_back(mk(U,       16'h7FFF, 1, 0, 1, 0, 0, 0, 4'b0010, 4'b0010, 1, 0, 0));
        vecs.push_back(mk(NO,      16'h0000, 0, 0, 0, 1, 0, 0, 4'b0010, 4'b0010, 0, 0, 0));
        vecs.push_back(mk(U,       16'h8001, 0, 1, 1, 0, 0, 0, 4'b1001, 4'b1001, 0, 0, 0));
        vecs.push_back(mk(NO,      16'h0000, 0, 0, 0, 1, 0, 0, 4'b1001, 4'b1001, 0, 1, 0));
        vecs.push_back(mk(U,       16'h0000, 1, 1, 0, 1, 0, 0, 4'b0101, 4'b0101, 0, 1, 1));
        vecs.push_back(mk(NO,      16'h0000, 0, 0, 0, 0, 0, 1, 4'b0101, 4'b0101, 0, 1, 0));
        vecs.push_back(mk(NO,      16'h0000, 0, 0, 0, 0, 1, 0, 4'b1001, 4'b1001, 0, 0, 0));
        vecs.push_back(mk(NO,      16'h0000, 0, 0, 0, 0, 1, 0, 4'b0010, 4'b0010, 1, 0, 0));
        vecs.push_back(mk(NO,      16'h0000, 0, 0, 0, 0, 1, 0, 4'b0010, 4'b0010, 1, 0, 1));
        vecs.push_back(mk(U,       16'h4000, 1, 1, 1, 0, 1, 0, 4'b0011, 4'b0011, 1, 0, 1));
        vecs.push_back(mk(NO,      16'h0000, 0, 0, 0, 0, 0, 1, 4'b0011, 4'b0011, 1, 0, 0));
        vecs.push_back(mk(NO,      16'h0000, 0, 0, 0, 1, 0, 0, 4'b0011, 4'b0011, 0, 0, 0));
        vecs.push_back(mk(U,       16'hC000, 0, 0, 0, 1, 1, 0, 4'b1011, 4'b1011, 0, 0, 1));
        vecs.push_back(mk(NO,      16'h0000, 0, 0, 0, 1, 1, 1, 4'b1011, 4'b1011, 0, 0, 1));
        vecs.push_back(mk(NO,      16'h0000, 0, 0, 0, 0, 0, 1, 4'b1011, 4'b1011, 0, 0, 0));
        vecs.push_back(mk(NO,      16'h0000, 0, 0, 0, 0, 1, 0, 4'b0011, 4'b0011, 1, 0, 0));
        vecs.push_back(mk(NO,      16'h0000, 0, 0, 0, 0, 1, 0, 4'b0011, 4'b0011, 1, 0, 1));

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_flags", -1, flags, 4'b0000);
        chk("reset_empty", -1, {3'b0, stack_empty}, 4'd1);
        chk("reset_full",  -1, {3'b0, stack_full},  4'd0);
        chk("reset_err",   -1, {3'b0, err},         4'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            {in_valid, set_flags, cond_pass, flush} = vecs[i].qual;
            alu_result   = vecs[i].res;
            alu_carry    = vecs[i].ca;
            alu_overflow = vecs[i].ov;
            update_cv    = vecs[i].cv;
            save         = vecs[i].sv;
            restore      = vecs[i].rs;
            err_clr      = vecs[i].ec;
            #1;
            chk("bypass", i, flags_bypass, vecs[i].byp);
            @(posedge clk);
            #1;
            chk("flags", i, flags, vecs[i].fl);
            chk("empty", i, {3'b0, stack_empty}, {3'b0, vecs[i].em});
            chk("full",  i, {3'b0, stack_full},  {3'b0, vecs[i].fu});
            chk("err",   i, {3'b0, err},         {3'b0, vecs[i].er});
        end

        // Asynchronous reset in the middle of a qualifying update, with a
        // saved entry and err set beforehand
        @(negedge clk);
        drive_idle();
        save = 1'b1;
        @(negedge clk);
        drive_idle();
        {in_valid, set_flags, cond_pass, flush} = U;
        alu_result = 16'h8000;
        update_cv  = 1'b1;
        alu_carry  = 1'b1;
        #1;
        chk("pre_rst_empty", -2, {3'b0, stack_empty}, 4'd0);
        chk("pre_rst_err",   -2, {3'b0, err},         4'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_flags", -2, flags, 4'b0000);
        chk("async_rst_empty", -2, {3'b0, stack_empty}, 4'd1);
        chk("async_rst_err",   -2, {3'b0, err},         4'd0);
        alu_result = 16'h0000;
        @(posedge clk);
        #1;
        chk("held_rst_flags", -2, flags, 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        drive_idle();
        @(posedge clk);
        #1;
        chk("post_rst_flags", -2, flags, 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_flag_register
`default_nettype wire
